warp_regfile_mw: RTL and testbench

Multi-warp vector register file. It holds REGS_PER_THREAD registers per thread for every thread of NUM_WARPS resident warps, and sits between the warp scheduler/decoder and the ALU/LSU lanes of a core. Relative to the single-warp register file, it adds:
- a registered read port with a valid/ready handshake;
- a masked write port with source select and write-to-read bypass;
- per-warp context registers that source the read-only special registers;
- a sequential per-warp clear engine.

---
 rtl/warp_regfile_mw.sv | 174 +++++++++++++++++
 tb/tb_warp_regfile_mw.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/warp_regfile_mw.sv
// Multi-warp vector register file: registered read port with handshake, masked
// write port with bypass, per-warp context for special registers, and a clear engine.
module warp_regfile_mw #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 8,
    parameter int REGS_PER_THREAD  = 32,
    parameter int DATA_W           = 32,
    localparam int WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int REG_W  = $clog2(REGS_PER_THREAD),
    localparam int LANE_W = THREADS_PER_WARP * DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_valid,
    input  logic [WARP_W-1:0]           cfg_warp,
    input  logic [DATA_W-1:0]           cfg_warp_id,
    input  logic [DATA_W-1:0]           cfg_block_id,
    input  logic [DATA_W-1:0]           cfg_block_size,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [WARP_W-1:0]           rd_warp,
    input  logic [REG_W-1:0]            rs1_addr,
    input  logic [REG_W-1:0]            rs2_addr,
    input  logic [THREADS_PER_WARP-1:0] rd_mask,
    output logic                        rd_resp_valid,
    output logic [LANE_W-1:0]           rs1_data,
    output logic [LANE_W-1:0]           rs2_data,
    input  logic                        wr_valid,
    input  logic [WARP_W-1:0]           wr_warp,
    input  logic [REG_W-1:0]            wr_addr,
    input  logic [THREADS_PER_WARP-1:0] wr_mask,
    input  logic [1:0]                  wr_src,
    input  logic [LANE_W-1:0]           alu_out,
    input  logic [LANE_W-1:0]           lsu_out,
    input  logic [LANE_W-1:0]           next_pc,
    input  logic                        clr_valid,
    input  logic [WARP_W-1:0]           clr_warp,
    output logic                        busy,
    output logic                        dbg_state
);

    // Read handshake: a request transfers on a cycle where rd_req_valid && rd_req_ready;
    // its data appears with rd_resp_valid exactly one cycle later. Writes have no backpressure.
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] regs [NUM_WARPS][REGS_PER_THREAD][THREADS_PER_WARP];
    logic [DATA_W-1:0] ctx_warp_id    [NUM_WARPS];
    logic [DATA_W-1:0] ctx_block_id   [NUM_WARPS];
    logic [DATA_W-1:0] ctx_block_size [NUM_WARPS];

    logic [REG_W-1:0]            ptr;
    logic [WARP_W-1:0]           clr_warp_q;
    logic [THREADS_PER_WARP-1:0] wr_lane_en;
    logic [LANE_W-1:0]           wr_data;
    logic [LANE_W-1:0]           rs1_next, rs2_next;
    logic                        rd_accept, clr_start;

    assign rd_accept  = rd_req_valid && rd_req_ready;
    assign clr_start  = (state_q == IDLE) && clr_valid;
    assign wr_lane_en = (wr_valid && wr_src != 2'd3 && wr_addr >= REG_W'(4)) ? wr_mask : '0;

    always_comb begin
        wr_data = alu_out;
        case (wr_src)
            2'd1:    wr_data = lsu_out;
            2'd2:    wr_data = next_pc;
            default: wr_data = alu_out;
        endcase
    end

    // Special registers come from context; stored registers honour same-cycle write bypass.
    function automatic logic [DATA_W-1:0] read_lane(input logic [REG_W-1:0] addr, input int t);
        logic [DATA_W-1:0] v;
        v = '0;
        if (rd_mask[t]) begin
            if (addr == REG_W'(1))
                v = ctx_warp_id[rd_warp] * DATA_W'(THREADS_PER_WARP) + DATA_W'(t);
            else if (addr == REG_W'(2))
                v = ctx_block_id[rd_warp];
            else if (addr == REG_W'(3))
                v = ctx_block_size[rd_warp];
            else if (addr >= REG_W'(4)) begin
                if (wr_lane_en[t] && wr_warp == rd_warp && wr_addr == addr)
                    v = wr_data[t*DATA_W +: DATA_W];
                else
                    v = regs[rd_warp][addr][t];
            end
        end
        return v;
    endfunction

    always_comb begin
        rs1_next = '0;
        rs2_next = '0;
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
            rs1_next[t*DATA_W +: DATA_W] = read_lane(rs1_addr, t);
            rs2_next[t*DATA_W +: DATA_W] = read_lane(rs2_addr, t);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_valid) state_d = CLEAR;
            CLEAR:   if (ptr == REG_W'(REGS_PER_THREAD - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == CLEAR);
        rd_req_ready = (state_q == IDLE);
        dbg_state    = state_q;
    end

    // The clear assignment comes after the write so it wins on a same-register collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++)
                for (int r = 0; r < REGS_PER_THREAD; r++)
                    for (int t = 0; t < THREADS_PER_WARP; t++)
                        regs[w][r][t] <= '0;
            ptr        <= '0;
            clr_warp_q <= '0;
        end else begin
            for (int t = 0; t < THREADS_PER_WARP; t++)
                if (wr_lane_en[t]) regs[wr_warp][wr_addr][t] <= wr_data[t*DATA_W +: DATA_W];
            if (state_q == CLEAR) begin
                for (int t = 0; t < THREADS_PER_WARP; t++)
                    regs[clr_warp_q][ptr][t] <= '0;
                ptr <= ptr + REG_W'(1);
            end else if (clr_start) begin
                clr_warp_q <= clr_warp;
                ptr        <= REG_W'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                ctx_warp_id[w]    <= '0;
                ctx_block_id[w]   <= '0;
                ctx_block_size[w] <= '0;
            end
        end else if (cfg_valid) begin
            ctx_warp_id[cfg_warp]    <= cfg_warp_id;
            ctx_block_id[cfg_warp]   <= cfg_block_id;
            ctx_block_size[cfg_warp] <= cfg_block_size;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_resp_valid <= 1'b0;
            rs1_data      <= '0;
            rs2_data      <= '0;
        end else begin
            rd_resp_valid <= rd_accept;
            if (rd_accept) begin
                rs1_data <= rs1_next;
                rs2_data <= rs2_next;
            end
        end
    end

endmodule

// File: tb/tb_warp_regfile_mw.sv
// Bench for warp_regfile_mw: directed vectors, expected read responses queued at issue
// and compared by a monitor when rd_resp_valid is seen.
module tb_warp_regfile_mw;

    localparam int LW = 256;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_valid;
    logic [1:0]     cfg_warp;
    logic [31:0]    cfg_warp_id, cfg_block_id, cfg_block_size;
    logic           rd_req_valid, rd_req_ready;
    logic [1:0]     rd_warp;
    logic [4:0]     rs1_addr, rs2_addr;
    logic [7:0]     rd_mask;
    logic           rd_resp_valid;
    logic [LW-1:0]  rs1_data, rs2_data;
    logic           wr_valid;
    logic [1:0]     wr_warp;
    logic [4:0]     wr_addr;
    logic [7:0]     wr_mask;
    logic [1:0]     wr_src;
    logic [LW-1:0]  alu_out, lsu_out, next_pc;
    logic           clr_valid;
    logic [1:0]     clr_warp;
    logic           busy, dbg_state;

    logic [2*LW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    warp_regfile_mw dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_warp(cfg_warp), .cfg_warp_id(cfg_warp_id),
        .cfg_block_id(cfg_block_id), .cfg_block_size(cfg_block_size),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_warp(rd_warp),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_mask(rd_mask),
        .rd_resp_valid(rd_resp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wr_valid(wr_valid), .wr_warp(wr_warp), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_src(wr_src), .alu_out(alu_out), .lsu_out(lsu_out), .next_pc(next_pc),
        .clr_valid(clr_valid), .clr_warp(clr_warp), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // helpers
    function automatic logic [LW-1:0] lanes(input logic [31:0] base, input logic [31:0] step,
                                            input logic [7:0] mask);
        logic [LW-1:0] v;
        v = '0;
        for (int t = 0; t < 8; t++)
            if (mask[t]) v[t*32 +: 32] = base + step * t;
        return v;
    endfunction

    task automatic check(input string name, input logic [2*LW-1:0] act, input logic [2*LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cfg_valid = 1'b0; rd_req_valid = 1'b0; wr_valid = 1'b0; clr_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [7:0] m, input logic [LW-1:0] e1, input logic [LW-1:0] e2);
        check("rd_req_ready", {511'd0, rd_req_ready}, 512'd1);
        rd_req_valid = 1'b1; rd_warp = w; rs1_addr = a1; rs2_addr = a2; rd_mask = m;
        exp_q.push_back({e1, e2});
    endtask

    task automatic set_write(input logic [1:0] w, input logic [4:0] a, input logic [7:0] m,
                             input logic [1:0] src, input logic [LW-1:0] d);
        wr_valid = 1'b1; wr_warp = w; wr_addr = a; wr_mask = m; wr_src = src;
        alu_out = (src == 2'd0) ? d : ~d;
        lsu_out = (src == 2'd1) ? d : ~d;
        next_pc = (src == 2'd2) ? d : ~d;
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic [31:0] id, input logic [31:0] bid,
                           input logic [31:0] bsz);
        cfg_valid = 1'b1; cfg_warp = w; cfg_warp_id = id; cfg_block_id = bid; cfg_block_size = bsz;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && rd_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 512'd1, 512'd0);
            end else begin
                logic [2*LW-1:0] e;
                e = exp_q.pop_front();
                check("rs1_data", {256'd0, rs1_data}, {256'd0, e[2*LW-1:LW]});
                check("rs2_data", {256'd0, rs2_data}, {256'd0, e[LW-1:0]});
            end
        end
    end

    initial begin
        reset = 1'b1;
        cfg_valid = 0; cfg_warp = 0; cfg_warp_id = 0; cfg_block_id = 0; cfg_block_size = 0;
        rd_req_valid = 0; rd_warp = 0; rs1_addr = 0; rs2_addr = 0; rd_mask = 0;
        wr_valid = 0; wr_warp = 0; wr_addr = 0; wr_mask = 0; wr_src = 0;
        alu_out = '0; lsu_out = '0; next_pc = '0; clr_valid = 0; clr_warp = 0;
        #3;
        check("reset_resp_valid", {511'd0, rd_resp_valid}, 512'd0);
        check("reset_busy", {511'd0, busy}, 512'd0);
        check("reset_ready", {511'd0, rd_req_ready}, 512'd1);
        check("reset_data", {rs1_data, rs2_data}, 512'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: context and special registers
        set_cfg(2'd2, 32'd5, 32'd7, 32'd64); tick();
        issue_read(2'd2, 5'd1, 5'd3, 8'hFF, lanes(40, 1, 8'hFF), lanes(64, 0, 8'hFF)); tick();
        issue_read(2'd2, 5'd0, 5'd2, 8'hFF, '0, lanes(7, 0, 8'hFF)); tick();
        set_cfg(2'd1, 32'd1, 32'd3, 32'd16);
        issue_read(2'd1, 5'd1, 5'd2, 8'hFF, lanes(0, 1, 8'hFF), '0); tick();
        issue_read(2'd1, 5'd1, 5'd2, 8'hFF, lanes(8, 1, 8'hFF), lanes(3, 0, 8'hFF)); tick();

        // 2: masked writes, dropped writes, source select
        set_write(2'd1, 5'd10, 8'h0F, 2'd0, lanes(32'h100, 1, 8'hFF)); tick();
        issue_read(2'd1, 5'd10, 5'd10, 8'hFF, lanes(32'h100, 1, 8'h0F), lanes(32'h100, 1, 8'h0F)); tick();
        set_write(2'd1, 5'd2, 8'hFF, 2'd0, lanes(32'h999, 1, 8'hFF)); tick();
        set_write(2'd1, 5'd11, 8'hFF, 2'd3, lanes(32'h777, 1, 8'hFF)); tick();
        set_write(2'd1, 5'd12, 8'hFF, 2'd2, lanes(32'h200, 4, 8'hFF)); tick();
        issue_read(2'd1, 5'd2, 5'd11, 8'hFF, lanes(3, 0, 8'hFF), '0); tick();
        issue_read(2'd1, 5'd12, 5'd10, 8'hFF, lanes(32'h200, 4, 8'hFF), lanes(32'h100, 1, 8'h0F)); tick();

        // 3: write-to-read bypass
        set_write(2'd0, 5'd5, 8'h01, 2'd1, lanes(32'hDEAD, 0, 8'hFF));
        issue_read(2'd0, 5'd5, 5'd4, 8'hFF, lanes(32'hDEAD, 0, 8'h01), '0); tick();
        issue_read(2'd0, 5'd5, 5'd4, 8'hFF, lanes(32'hDEAD, 0, 8'h01), '0); tick();
        set_write(2'd0, 5'd5, 8'h02, 2'd0, lanes(32'hBEEF, 0, 8'hFF));
        issue_read(2'd0, 5'd5, 5'd5, 8'hFF, lanes(32'hDEAD, 0, 8'h01) | lanes(32'hBEEF, 0, 8'h02),
                   lanes(32'hDEAD, 0, 8'h01) | lanes(32'hBEEF, 0, 8'h02)); tick();

        // 4: clear engine
        for (int a = 4; a < 32; a++) begin
            set_write(2'd3, 5'(a), 8'hFF, 2'd1, lanes(32'h3000 + a * 16, 1, 8'hFF)); tick();
        end
        set_write(2'd0, 5'd6, 8'hFF, 2'd0, lanes(32'h600, 1, 8'hFF)); tick();
        set_write(2'd2, 5'd20, 8'hFF, 2'd0, lanes(32'h500, 1, 8'hFF)); tick();
        clr_valid = 1'b1; clr_warp = 2'd3; tick();
        for (int i = 0; i < 28; i++) begin
            check("clear_busy", {510'd0, busy, rd_req_ready}, 512'd2);
            check("clear_state", {511'd0, dbg_state}, 512'd1);
            if (i == 6) set_write(2'd3, 5'd10, 8'hFF, 2'd0, lanes(32'h1234, 1, 8'hFF));
            if (i == 7) set_write(2'd0, 5'd7, 8'hFF, 2'd2, lanes(32'h700, 1, 8'hFF));
            if (i == 8) begin clr_valid = 1'b1; clr_warp = 2'd0; end
            tick();
        end
        check("clear_done", {510'd0, busy, rd_req_ready}, 512'd1);
        issue_read(2'd3, 5'd4, 5'd31, 8'hFF, '0, '0); tick();
        issue_read(2'd3, 5'd10, 5'd30, 8'hFF, '0, '0); tick();
        issue_read(2'd0, 5'd6, 5'd5, 8'hFF, lanes(32'h600, 1, 8'hFF),
                   lanes(32'hDEAD, 0, 8'h01) | lanes(32'hBEEF, 0, 8'h02)); tick();

        // 5: read mask and back-to-back reads
        issue_read(2'd2, 5'd20, 5'd1, 8'hA5, lanes(32'h500, 1, 8'hA5), lanes(40, 1, 8'hA5)); tick();
        check("b2b_valid", {511'd0, rd_resp_valid}, 512'd1);
        issue_read(2'd0, 5'd6, 5'd7, 8'hFF, lanes(32'h600, 1, 8'hFF), lanes(32'h700, 1, 8'hFF)); tick();
        check("b2b_valid", {511'd0, rd_resp_valid}, 512'd1);
        issue_read(2'd2, 5'd3, 5'd2, 8'hFF, lanes(64, 0, 8'hFF), lanes(7, 0, 8'hFF)); tick();
        check("b2b_valid", {511'd0, rd_resp_valid}, 512'd1);
        issue_read(2'd1, 5'd10, 5'd12, 8'hF0, '0, lanes(32'h200, 4, 8'hF0)); tick();
        check("b2b_valid", {511'd0, rd_resp_valid}, 512'd1);
        tick();
        check("resp_single_cycle", {511'd0, rd_resp_valid}, 512'd0);
        check("queue_drained", 512'(exp_q.size()), 512'd0);

        // 6: asynchronous reset in the middle of a clear
        clr_valid = 1'b1; clr_warp = 2'd0; tick();
        repeat (9) tick();
        check("pre_reset_busy", {511'd0, busy}, 512'd1);
        reset = 1'b1;
        #1;
        check("async_busy", {511'd0, busy}, 512'd0);
        check("async_resp_valid", {511'd0, rd_resp_valid}, 512'd0);
        check("async_data", {rs1_data, rs2_data}, 512'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        issue_read(2'd0, 5'd6, 5'd1, 8'hFF, '0, lanes(0, 1, 8'hFF)); tick();
        issue_read(2'd2, 5'd20, 5'd3, 8'hFF, '0, '0); tick();
        issue_read(2'd3, 5'd2, 5'd1, 8'hFF, '0, lanes(0, 1, 8'hFF)); tick();
        repeat (3) tick();
        check("final_queue_empty", 512'(exp_q.size()), 512'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
